// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encodings,
// default widths/timings and a small helper.
// The package is named stopwatch_pkg and is imported by every stopwatch file.
package stopwatch_pkg;

    // Default width of the timer value / display bus.
    localparam int DISP_W_DEF = 24;

    // Default debounce window: 20 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Controller states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } sw_state_e;

    // The timer datapath counts in RUNNING and keeps counting while a lap is shown.
    function automatic logic timer_on(input sw_state_e s);
        return (s == RUNNING) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Link between the stopwatch controller and the timer datapath.
// master: controller side (drives run/clear, reads the live count).
// slave : datapath side (drives the live count, obeys run/clear).
// timer_run is a level enable; timer_clr is a single-cycle clear pulse.
// There is no valid/ready handshake on this link: time_in is sampled
// whenever it is needed and the two controls are plain registered levels.
interface stopwatch_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int DISP_W = DISP_W_DEF
);
    logic [DISP_W-1:0] time_in;
    logic              timer_run;
    logic              timer_clr;

    modport master (
        input  time_in,
        output timer_run,
        output timer_clr
    );

    modport slave (
        output time_in,
        input  timer_run,
        input  timer_clr
    );

endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer, counting debouncer and press detector
// for one raw push-button. The debounced level only follows the
// synchronized input after it has differed for DEBOUNCE_CYCLES consecutive
// cycles; any bounce back restarts the count. key_press is a single-cycle
// pulse on the debounced 0->1 edge (release produces nothing).
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_dly_q;

    // Synchronize the raw key, qualify changes by a stable-run counter,
    // and keep a one-cycle delayed level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b00;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_raw};
            level_dly_q <= level_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign key_level = level_q;
    assign key_press = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-button stopwatch controller.
// start/stop (ss) and lap/clear (lc) keys are debounced, turned into press
// events and drive an IDLE/RUNNING/PAUSED(/LAP) state machine that enables
// and clears an external timer datapath and selects the displayed value.
// Optional feature macro: STOPWATCH_CTRL_LAP_EN adds the LAP state and the
// lap register; without it lc is ignored in RUNNING and the display is live.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DISP_W          = DISP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_ss,
    input  logic              key_lc,
    stopwatch_ctrl_if.master  tmr,
    output logic [DISP_W-1:0] disp_out,
    output logic              lap_active,
    output logic [1:0]        state_o
);

    logic ss_level, ss_press;
    logic lc_level, lc_press;
    logic ss_ev, lc_ev;

    sw_state_e state_q, state_d;
    logic      run_q, run_d;
    logic      clr_q, clr_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_ss (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_ss),
        .key_level (ss_level),
        .key_press (ss_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_lc (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_lc),
        .key_level (lc_level),
        .key_press (lc_press)
    );

    // A press pulse always coincides with a high debounced level; the AND
    // just makes the event definition explicit. ss wins over lc.
    assign ss_ev = ss_press & ss_level;
    assign lc_ev = lc_press & lc_level & ~ss_ev;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic [DISP_W-1:0] lap_q, lap_d;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
        lap_d   = lap_q;
`endif
        case (state_q)
            IDLE: begin
                if (ss_ev) state_d = RUNNING;
            end
            RUNNING: begin
                if (ss_ev) begin
                    state_d = PAUSED;
`ifdef STOPWATCH_CTRL_LAP_EN
                end else if (lc_ev) begin
                    state_d = LAP;
                    lap_d   = tmr.time_in;
`endif
                end
            end
            PAUSED: begin
                if (ss_ev) begin
                    state_d = RUNNING;
                end else if (lc_ev) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            LAP: begin
`ifdef STOPWATCH_CTRL_LAP_EN
                if (ss_ev) begin
                    state_d = PAUSED;
                end else if (lc_ev) begin
                    state_d = RUNNING;
                end
`else
                // Unreachable without the lap feature; recover to IDLE.
                state_d = IDLE;
`endif
            end
        endcase
        run_d = timer_on(state_d);
    end

    // State and datapath controls, registered together so the clear pulse
    // lands with the move to IDLE and never overlaps timer_run rising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    // Lap register: frozen copy of the live count taken on entry to LAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_active = (state_q == LAP);
    assign disp_out   = lap_active ? lap_q : tmr.time_in;
`else
    assign lap_active = 1'b0;
    assign disp_out   = tmr.time_in;
`endif

    assign tmr.timer_run = run_q;
    assign tmr.timer_clr = clr_q;
    assign state_o       = state_q;

endmodule
